// File: rtl/ps2_pkg.sv
// ps2_pkg
//  Shared definitions for the PS/2 keyboard receiver.
//  - PS2_BREAK / PS2_EXT : set-2 prefix bytes (key release / extended key)
//  - ps2_state_e         : receive FSM encoding, also exported on the debug state field
//  - ps2_parity_ok       : odd-parity check over the 8 data bits plus the parity bit
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: the nine bits together carry an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if
//  Key-event bus from the PS/2 receiver to its consumer.
//  Event semantics: scan_valid is a one-cycle strobe; in that cycle scan_code, is_break and
//  is_extended carry the new event and stay held until the next strobe. There is no ready
//  back-pressure: the consumer must take the event in the strobe cycle. frame_err is a
//  one-cycle strobe reporting a dropped frame and never coincides with scan_valid.
//  Signals:
//   scan_code   [7:0] last decoded scan code
//   scan_valid        event strobe
//   is_break          event was preceded by F0
//   is_extended       event was preceded by E0
//   frame_err         bad start/parity/stop or timeout strobe
//   busy              a frame is in progress
//   dbg_state         receive FSM state, for observation only
//  Modports: master = receiver side (drives), slave = consumer side (samples).
interface ps2_keyboard_rx_if;
  import ps2_pkg::*;

  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;
  ps2_state_e dbg_state;

  modport master (
    output scan_code, scan_valid, is_break, is_extended, frame_err, busy, dbg_state
  );

  modport slave (
    input scan_code, scan_valid, is_break, is_extended, frame_err, busy, dbg_state
  );

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//  Conditions one asynchronous PS/2 line: 2-flop synchroniser, then a glitch filter that
//  only moves the filtered level after FILTER_LEN consecutive synced samples disagree with
//  it, then a one-cycle pulse on each filtered 1->0 transition.
//  Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset (line assumed idle high)
//   line_i  in  raw asynchronous pin
//   fall_o  out one-cycle pulse, high in the cycle the filtered level becomes 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts how many consecutive samples have already disagreed with level_q; the
  // FILTER_LEN-th disagreeing sample flips the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        fall_q  <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//  Receives device-to-host PS/2 keyboard frames and turns them into set-2 key events.
//  F0 / E0 prefix bytes are absorbed into pending flags and attached to the next real code.
//  Ports:
//   clk      in  system clock (50 MHz nominal)
//   rst      in  synchronous active-high reset
//   ps2_clk  in  raw PS/2 clock pin, idle high
//   ps2_dat  in  raw PS/2 data pin, idle high
//   evt      master modport of ps2_keyboard_rx_if: scan_code/scan_valid/is_break/
//            is_extended/frame_err/busy/dbg_state
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  ps2_keyboard_rx_if.master     evt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  // Line conditioning
  logic fall;
  logic dat_sync1_q;
  logic dat_sync2_q;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk),
    .fall_o (fall)
  );

  // Data needs no filtering: it is only looked at on a filtered clock fall, long after
  // the device has settled it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_sync1_q <= 1'b1;
      dat_sync2_q <= 1'b1;
    end else begin
      dat_sync1_q <= ps2_dat;
      dat_sync2_q <= dat_sync1_q;
    end
  end

  // Receive state
  ps2_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_pend_q, brk_pend_d;
  logic          ext_pend_q, ext_pend_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_valid_q, scan_valid_d;
  logic          is_break_q, is_break_d;
  logic          is_extended_q, is_extended_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      tmo_q         <= '0;
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      is_break_q    <= 1'b0;
      is_extended_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      tmo_q         <= tmo_d;
      brk_pend_q    <= brk_pend_d;
      ext_pend_q    <= ext_pend_d;
      scan_code_q   <= scan_code_d;
      scan_valid_q  <= scan_valid_d;
      is_break_q    <= is_break_d;
      is_extended_q <= is_extended_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    tmo_d         = tmo_q;
    brk_pend_d    = brk_pend_q;
    ext_pend_d    = ext_pend_q;
    scan_code_d   = scan_code_q;
    scan_valid_d  = 1'b0;
    is_break_d    = is_break_q;
    is_extended_d = is_extended_q;
    frame_err_d   = 1'b0;

    // Inactivity counter: idle and every clock fall restart it; it saturates so a stuck
    // line can never wrap it back into range.
    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          // A fall with data high is not a start bit; ignore it silently.
          if (!dat_sync2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so shift in from the top.
          shift_d  = {dat_sync2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = dat_sync2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ps2_parity_ok(shift_q, par_q) && dat_sync2_q) begin
            if (shift_q == PS2_BREAK) begin
              brk_pend_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              ext_pend_d = 1'b1;
            end else begin
              scan_code_d   = shift_q;
              is_break_d    = brk_pend_q;
              is_extended_d = ext_pend_q;
              scan_valid_d  = 1'b1;
              brk_pend_d    = 1'b0;
              ext_pend_d    = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            brk_pend_d  = 1'b0;
            ext_pend_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_MAX) begin
      // Abandoned frame: a fall in this same cycle would have taken the branch above.
      state_d     = ST_IDLE;
      bitcnt_d    = '0;
      frame_err_d = 1'b1;
      brk_pend_d  = 1'b0;
      ext_pend_d  = 1'b0;
    end
  end

  assign evt.scan_code   = scan_code_q;
  assign evt.scan_valid  = scan_valid_q;
  assign evt.is_break    = is_break_q;
  assign evt.is_extended = is_extended_q;
  assign evt.frame_err   = frame_err_q;
  assign evt.busy        = (state_q != ST_IDLE);
  assign evt.dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx. PS/2 clock is scaled down (HALF cycles per phase)
// together with a shortened timeout so the whole run stays small.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN = 8;
  localparam int TMO        = 400;
  localparam int HALF       = 40;
  // Pin fall -> 2 sync flops -> FILTER_LEN filter samples -> fall pulse -> counter cleared,
  // then TMO counts, then one cycle to register frame_err.
  localparam int TMO_LAT    = TMO + 12;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_keyboard_rx_if evt ();

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .evt     (evt)
  );

  // Event monitor: cumulative counts sampled away from the active edge
  int v_cnt = 0;
  int e_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] last_code = '0;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;

  always @(negedge clk) begin
    if (evt.scan_valid) begin
      v_cnt     <= v_cnt + 1;
      last_code <= evt.scan_code;
      last_brk  <= evt.is_break;
      last_ext  <= evt.is_extended;
    end
    if (evt.frame_err) e_cnt <= e_cnt + 1;
    if (evt.scan_valid && evt.frame_err) both_cnt <= both_cnt + 1;
    if (evt.busy) busy_cnt <= busy_cnt + 1;
  end

  // Scoreboard bookkeeping
  int tests = 0;
  int fails = 0;
  int v0, e0, b0;
  int t_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    @(negedge clk);
    v0 = v_cnt;
    e0 = e_cnt;
    b0 = busy_cnt;
  endtask

  // Driver tasks: data changes mid-high phase, clock falls, stays low HALF cycles
  task automatic ps2_bit(input logic b);
    repeat (HALF / 2) @(posedge clk);
    #1 ps2_dat = b;
    repeat (HALF / 2) @(posedge clk);
    #1 ps2_clk = 1'b0;
    t_fall = cyc;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_bit(stop);
    #1 ps2_dat = 1'b1;
    repeat (HALF + 20) @(posedge clk);
  endtask

  task automatic send_partial(input logic [7:0] code, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(code[i]);
  endtask

  task automatic expect_event(input string tag, input logic [7:0] code,
                              input logic brk, input logic ext);
    @(negedge clk);
    check({tag, "_valid_cnt"}, 32'(v_cnt - v0), 32'd1);
    check({tag, "_err_cnt"}, 32'(e_cnt - e0), 32'd0);
    check({tag, "_code"}, 32'(last_code), 32'(code));
    check({tag, "_brk"}, 32'(last_brk), 32'(brk));
    check({tag, "_ext"}, 32'(last_ext), 32'(ext));
  endtask

  task automatic expect_quiet(input string tag, input int errs);
    @(negedge clk);
    check({tag, "_valid_cnt"}, 32'(v_cnt - v0), 32'd0);
    check({tag, "_err_cnt"}, 32'(e_cnt - e0), 32'(errs));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code"}, 32'(evt.scan_code), 32'h00);
    check({tag, "_valid"}, 32'(evt.scan_valid), 32'd0);
    check({tag, "_brk"}, 32'(evt.is_break), 32'd0);
    check({tag, "_ext"}, 32'(evt.is_extended), 32'd0);
    check({tag, "_err"}, 32'(evt.frame_err), 32'd0);
    check({tag, "_busy"}, 32'(evt.busy), 32'd0);
    check({tag, "_state"}, 32'(evt.dbg_state), 32'(ST_IDLE));
  endtask

  initial begin : stim
    int waited;
    bit seen;

    // Reset
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    // 1: plain make code 1C (popcount 3 -> parity 0)
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_event("t1_1c", 8'h1C, 1'b0, 1'b0);

    // 2: F0 1C (F0 popcount 4 -> parity 1)
    snap();
    send_frame(8'hF0, 1'b1, 1'b1);
    expect_quiet("t2_f0", 0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_event("t2_brk_1c", 8'h1C, 1'b1, 1'b0);

    // 3: E0 F0 75 (E0 popcount 3, 75 popcount 5 -> parity 0), then bare 75
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    expect_quiet("t3_prefix", 0);
    snap();
    send_frame(8'h75, 1'b0, 1'b1);
    expect_event("t3_ext_brk_75", 8'h75, 1'b1, 1'b1);
    snap();
    send_frame(8'h75, 1'b0, 1'b1);
    expect_event("t3_plain_75", 8'h75, 1'b0, 1'b0);

    // 4: parity error, then recovery
    snap();
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_quiet("t4_bad_par", 1);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_event("t4_recover", 8'h1C, 1'b0, 1'b0);

    // 4b: stop-bit error discards a pending F0
    snap();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    expect_quiet("t4b_bad_stop", 1);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_event("t4b_no_brk", 8'h1C, 1'b0, 1'b0);

    // 5: timeout after 5 data bits
    snap();
    send_partial(8'h1C, 5);
    @(negedge clk);
    check("t5_busy_mid", 32'(evt.busy), 32'd1);
    check("t5_state_mid", 32'(evt.dbg_state), 32'(ST_DATA));
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < TMO + 200) begin
      @(negedge clk);
      waited++;
      if (evt.frame_err) seen = 1'b1;
    end
    check("t5_timeout_seen", 32'(seen), 32'd1);
    check("t5_timeout_lat", 32'(cyc - t_fall), 32'(TMO_LAT));
    @(negedge clk);
    check("t5_busy_after", 32'(evt.busy), 32'd0);
    check("t5_err_once", 32'(e_cnt - e0), 32'd1);
    check("t5_no_valid", 32'(v_cnt - v0), 32'd0);
    snap();
    send_frame(8'h75, 1'b0, 1'b1);
    expect_event("t5_recover", 8'h75, 1'b0, 1'b0);

    // 6a: FILTER_LEN-1 cycle low glitch with data low must not start a frame
    snap();
    #1 ps2_dat = 1'b0;
    repeat (5) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t6_glitch_busy", 32'(busy_cnt - b0), 32'd0);
    #1 ps2_dat = 1'b1;
    repeat (20) @(posedge clk);

    // 6b: reset mid-frame drops the frame and a pending F0
    snap();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_partial(8'h1C, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t6_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    ps2_dat = 1'b1;
    repeat (20) @(posedge clk);
    expect_quiet("t6_rst_quiet", 0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_event("t6_after_rst", 8'h1C, 1'b0, 1'b0);

    // Strobes never overlap across the whole run
    check("never_both", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
